y_pos_updater: RTL
==================

Name: y_pos_updater

Overview:
Producer side of the vertical-position interface used by the per-line Y checker. Once per frame, at the start of vertical blanking, it updates the two paddle Y positions from the player buttons and the ball Y position from its vertical velocity. Wall bounces and clamping are handled here. Outputs change only during V_BLANK, so downstream line checkers always see stable positions for the whole active frame.

Parameters:
PLAYER_HEIGHT_LOG, 9, width of paddle position outputs
BALL_HEIGHT_LOG, 9, width of ball position output
SCREEN_HEIGHT, 480, visible lines
PLAYER_LEN, 64, paddle height in lines
BALL_PIXSIZE, 8, ball height in lines
PLAYER_SPEED, 4, paddle step per frame
BALL_SPEED, 2, ball step per frame (base)

Ports:
CLK  in  1  system clock
rst  in  1  reset; synchronous to CLK, active-high
V_BLANK  in  1  vertical blanking flag from the video timing generator
p1Up, p1Down, p2Up, p2Down  in  1 each  player buttons, already synchronised
serve  in  1  re-centre the ball and reverse its direction
player1Pos  out  PLAYER_HEIGHT_LOG  paddle 1 top line
player2Pos  out  PLAYER_HEIGHT_LOG  paddle 2 top line
ballYPos  out  BALL_HEIGHT_LOG  ball top line
ballYDown  out  1  1 = ball moving toward larger Y
updateDone  out  1  one-cycle pulse when all positions are updated

Behaviour:
- Reset state (rst high at a CLK edge):
  - player1Pos = player2Pos = (SCREEN_HEIGHT-PLAYER_LEN)/2 = 208.
  - ballYPos = (SCREEN_HEIGHT-BALL_PIXSIZE)/2 = 236.
  - ballYDown = 1, updateDone = 0, FSM = IDLE.
  - vBlankBuf and vBlankPrev both reset to 1. If V_BLANK is already high when reset is released, no update happens until the next rising edge.
- rst asserted mid-update aborts the update and restores all reset values; no partial update survives.
- V_BLANK is registered into vBlankBuf, then into vBlankPrev. The trigger is vBlankBuf && !vBlankPrev.
- FSM is one-hot, with states IDLE, UPD_P1, UPD_P2, UPD_BALL, DONE, WAIT_LOW_BLANK:
  - IDLE -> UPD_P1 on trigger.
  - UPD_P1 -> UPD_P2 -> UPD_BALL -> DONE -> WAIT_LOW_BLANK, one state per cycle, unconditional.
  - WAIT_LOW_BLANK -> IDLE when vBlankBuf = 0.
- Latency: CLK edge k samples V_BLANK = 1. player1Pos updates at edge k+2, player2Pos at k+3, ballYPos and ballYDown at k+4. updateDone is high for exactly the cycle after k+4 (decoded from DONE).
- Paddle update, applied in its own UPD state using the buttons present at that edge. Let MAXP = SCREEN_HEIGHT-PLAYER_LEN = 416.
  - Up and Down both pressed, or neither pressed: no change.
  - Up only: pos = (pos >= PLAYER_SPEED) ? pos-PLAYER_SPEED : 0.
  - Down only: pos = (pos+PLAYER_SPEED >= MAXP) ? MAXP : pos+PLAYER_SPEED.
  - Arithmetic is one bit wider than the output so the sum cannot wrap.
- Ball update, applied in UPD_BALL with step s (= BALL_SPEED unless the optional feature is enabled). Let MAXB = SCREEN_HEIGHT-BALL_PIXSIZE = 472.
  - serve = 1 takes priority: ballYPos = 236, ballYDown inverted.
  - Otherwise, moving down: if ballYPos+s >= MAXB, then ballYPos = MAXB and ballYDown = 0; else ballYPos += s.
  - Otherwise, moving up: if ballYPos <= s, then ballYPos = 0 and ballYDown = 1; else ballYPos -= s.
- If V_BLANK drops before DONE, the sequence still completes; the FSM then passes straight through WAIT_LOW_BLANK. Exactly one update occurs per V_BLANK rising edge. A new rising edge is only recognised in IDLE.
- Buttons and serve are ignored outside their UPD state.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined:
  - Adds a speed register s, reset to BALL_SPEED.
  - Each wall bounce (clamp at 0 or MAXB) increments s by 1, saturating at 2*BALL_SPEED.
  - serve restores s to BALL_SPEED.
  - Width is clog2(2*BALL_SPEED)+1.
- Undefined: s is the constant BALL_SPEED and no register exists.

Test Plan:
- Reset, then V_BLANK pulse with no inputs -> paddles stay 208; ballYPos 236->238; updateDone high for 1 cycle, 5 cycles after the first V_BLANK-high sample.
- p1Up held across frames starting at player1Pos=6 -> 2, then 0, then stays 0. p2Down held with player2Pos=414 -> 416, stays 416. p1Up and p1Down both held -> no change.
- Ball at 470 moving down -> 472 with ballYDown=0. Next frame -> 470. Ball at 2 moving up -> 0 with ballYDown=1.
- serve=1 during the frame update with ball at 100, ballYDown=1 -> ballYPos=236, ballYDown=0.
- V_BLANK held high for 3 frames' worth of cycles -> exactly one update. V_BLANK high at reset release -> no update until it goes low then high.
- rst asserted in UPD_P2 after player1 moved to 204 -> all outputs return to reset values next cycle. With BALL_SPEEDUP_EN: two bounces -> steps of 3 then 4, then saturated at 4.

Source files
------------

// File: rtl/y_pos_updater_if.sv
//------------------------------------------------------------------------------
// y_pos_updater_if
// Vertical-position bus between y_pos_updater (master) and the per-line Y
// checkers (slave). All signals are driven by the master.
//
//   player1Pos  [PLAYER_HEIGHT_LOG]  paddle 1 top line
//   player2Pos  [PLAYER_HEIGHT_LOG]  paddle 2 top line
//   ballYPos    [BALL_HEIGHT_LOG]    ball top line
//   ballYDown   1                    1 = ball moving toward larger Y
//   updateDone  1                    one-cycle pulse when positions are updated
//------------------------------------------------------------------------------
interface y_pos_updater_if #(
   parameter int PLAYER_HEIGHT_LOG = 9,
   parameter int BALL_HEIGHT_LOG   = 9
);
   logic [PLAYER_HEIGHT_LOG-1:0] player1Pos;
   logic [PLAYER_HEIGHT_LOG-1:0] player2Pos;
   logic [BALL_HEIGHT_LOG-1:0]   ballYPos;
   logic                         ballYDown;
   logic                         updateDone;

   modport master (
      output player1Pos,
      output player2Pos,
      output ballYPos,
      output ballYDown,
      output updateDone
   );

   modport slave (
      input player1Pos,
      input player2Pos,
      input ballYPos,
      input ballYDown,
      input updateDone
   );
endinterface

// File: rtl/y_pos_updater.sv
//------------------------------------------------------------------------------
// y_pos_updater
// Once per frame, on the rising edge of V_BLANK, steps paddle 1, paddle 2 and
// then the ball (one per cycle), handling clamping and wall bounces. Positions
// only change during vertical blanking.
//
// Ports:
//   CLK                         system clock
//   rst                         synchronous, active-high reset
//   V_BLANK                     vertical blanking flag
//   p1Up, p1Down, p2Up, p2Down  player buttons (already synchronised)
//   serve                       re-centre the ball and reverse its direction
//   posIf (master)              player1Pos, player2Pos, ballYPos, ballYDown,
//                               updateDone
//
// Optional feature: define BALL_SPEEDUP_EN to make each wall bounce raise the
// ball step by one (saturating at 2*BALL_SPEED); serve restores BALL_SPEED.
//------------------------------------------------------------------------------
module y_pos_updater #(
   parameter int PLAYER_HEIGHT_LOG = 9,
   parameter int BALL_HEIGHT_LOG   = 9,
   parameter int SCREEN_HEIGHT     = 480,
   parameter int PLAYER_LEN        = 64,
   parameter int BALL_PIXSIZE      = 8,
   parameter int PLAYER_SPEED      = 4,
   parameter int BALL_SPEED        = 2
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             V_BLANK,
   input  logic             p1Up,
   input  logic             p1Down,
   input  logic             p2Up,
   input  logic             p2Down,
   input  logic             serve,
   y_pos_updater_if.master  posIf
);

   localparam int PW = PLAYER_HEIGHT_LOG;
   localparam int BW = BALL_HEIGHT_LOG;
   localparam int SW = $clog2(2 * BALL_SPEED) + 1;

   localparam logic [PW-1:0] P_INIT  = PW'((SCREEN_HEIGHT - PLAYER_LEN) / 2);
   localparam logic [PW-1:0] P_MAX   = PW'(SCREEN_HEIGHT - PLAYER_LEN);
   localparam logic [PW:0]   P_MAXW  = (PW + 1)'(SCREEN_HEIGHT - PLAYER_LEN);
   localparam logic [PW:0]   P_STEPW = (PW + 1)'(PLAYER_SPEED);
   localparam logic [PW-1:0] P_STEP  = PW'(PLAYER_SPEED);

   localparam logic [BW-1:0] B_INIT  = BW'((SCREEN_HEIGHT - BALL_PIXSIZE) / 2);
   localparam logic [BW-1:0] B_MAX   = BW'(SCREEN_HEIGHT - BALL_PIXSIZE);
   localparam logic [BW:0]   B_MAXW  = (BW + 1)'(SCREEN_HEIGHT - BALL_PIXSIZE);

   typedef enum logic [5:0] {
      IDLE           = 6'b000001,
      UPD_P1         = 6'b000010,
      UPD_P2         = 6'b000100,
      UPD_BALL       = 6'b001000,
      DONE           = 6'b010000,
      WAIT_LOW_BLANK = 6'b100000
   } state_t;

   state_t          state;
   state_t          nextState;
   logic            vBlankBuf;
   logic            vBlankPrev;
   logic            updateDoneC;

   logic [PW-1:0]   player1Pos;
   logic [PW-1:0]   player2Pos;
   logic [BW-1:0]   ballYPos;
   logic            ballYDown;

   logic [SW-1:0]   ballStep;
   logic [BW-1:0]   ballNextPos;
   logic            ballNextDown;
   logic            ballBounce;

   // Paddle step with clamping; sums are one bit wider so they cannot wrap.
   function automatic logic [PW-1:0] paddleNext(input logic [PW-1:0] pos,
                                                input logic up,
                                                input logic down);
      logic [PW:0] wide;
      logic [PW:0] sum;
      wide = {1'b0, pos};
      sum  = wide + P_STEPW;
      paddleNext = pos;
      unique case ({up, down})
         2'b10:   paddleNext = (wide >= P_STEPW) ? (pos - P_STEP) : '0;
         2'b01:   paddleNext = (sum >= P_MAXW) ? P_MAX : sum[PW-1:0];
         default: paddleNext = pos;
      endcase
   endfunction

   // Two-stage V_BLANK pipeline; resetting both to 1 suppresses a trigger when
   // V_BLANK is already high as reset is released.
   always_ff @(posedge CLK) begin
      if (rst) begin
         vBlankBuf  <= 1'b1;
         vBlankPrev <= 1'b1;
      end else begin
         vBlankBuf  <= V_BLANK;
         vBlankPrev <= vBlankBuf;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState   = state;
      updateDoneC = 1'b0;
      unique case (state)
         IDLE:           if (vBlankBuf && !vBlankPrev) nextState = UPD_P1;
         UPD_P1:         nextState = UPD_P2;
         UPD_P2:         nextState = UPD_BALL;
         UPD_BALL:       nextState = DONE;
         DONE: begin
            nextState   = WAIT_LOW_BLANK;
            updateDoneC = 1'b1;
         end
         WAIT_LOW_BLANK: if (!vBlankBuf) nextState = IDLE;
         default:        nextState = IDLE;
      endcase
   end

   // Ball step: serve wins, otherwise move and bounce off the walls.
   always_comb begin
      logic [BW:0] wide;
      logic [BW:0] stepW;
      wide         = {1'b0, ballYPos};
      stepW        = (BW + 1)'(ballStep);
      ballNextPos  = ballYPos;
      ballNextDown = ballYDown;
      ballBounce   = 1'b0;
      if (serve) begin
         ballNextPos  = B_INIT;
         ballNextDown = ~ballYDown;
      end else if (ballYDown) begin
         if (wide + stepW >= B_MAXW) begin
            ballNextPos  = B_MAX;
            ballNextDown = 1'b0;
            ballBounce   = 1'b1;
         end else begin
            ballNextPos  = ballYPos + BW'(ballStep);
         end
      end else begin
         if (wide <= stepW) begin
            ballNextPos  = '0;
            ballNextDown = 1'b1;
            ballBounce   = 1'b1;
         end else begin
            ballNextPos  = ballYPos - BW'(ballStep);
         end
      end
   end

`ifdef BALL_SPEEDUP_EN
   localparam logic [SW-1:0] S_BASE = SW'(BALL_SPEED);
   localparam logic [SW-1:0] S_MAX  = SW'(2 * BALL_SPEED);

   always_ff @(posedge CLK) begin
      if (rst) begin
         ballStep <= S_BASE;
      end else if (state == UPD_BALL) begin
         if (serve)                           ballStep <= S_BASE;
         else if (ballBounce && ballStep < S_MAX) ballStep <= ballStep + 1'b1;
      end
   end
`else
   assign ballStep = SW'(BALL_SPEED);
`endif

   always_ff @(posedge CLK) begin
      if (rst) begin
         player1Pos <= P_INIT;
         player2Pos <= P_INIT;
         ballYPos   <= B_INIT;
         ballYDown  <= 1'b1;
      end else begin
         unique case (state)
            UPD_P1:   player1Pos <= paddleNext(player1Pos, p1Up, p1Down);
            UPD_P2:   player2Pos <= paddleNext(player2Pos, p2Up, p2Down);
            UPD_BALL: begin
               ballYPos  <= ballNextPos;
               ballYDown <= ballNextDown;
            end
            default: ;
         endcase
      end
   end

   assign posIf.player1Pos = player1Pos;
   assign posIf.player2Pos = player2Pos;
   assign posIf.ballYPos   = ballYPos;
   assign posIf.ballYDown  = ballYDown;
   assign posIf.updateDone = updateDoneC;

endmodule
